procesador_lockin_snapshot_ctrl: RTL and testbench

//  Avalon-MM slave that sequences coherent capture of the four lock-in results
//  (phase/quadrature, up/down) into one snapshot the Nios reads safely.

---
 rtl/procesador_lockin_snapshot_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_procesador_lockin_snapshot_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/procesador_lockin_snapshot_ctrl.sv
// procesador_lockin_snapshot_ctrl
//   Avalon-MM slave that captures the four lock-in results (phase/quadrature,
//   up/down channels) into one coherent snapshot for the Nios to read.
//   It sequences arm, decimation, capture and ready, and it counts overruns
//   that arrive while a snapshot is still waiting to be read.
//   Single-shot and continuous modes are supported.
//
// Ports
//   clk, reset_n          single clock; asynchronous active-low reset
//   address/read/write    Avalon word address and strobes
//   writedata/readdata    Avalon data; readdata is registered (1-cycle latency)
//   in_valid              one-cycle strobe marking a new lock-in result set
//   in_fase_*/in_cuad_*   lock-in results, up and down channels
//   irq                   registered; high while a snapshot is ready
//
// Register map
//   0..3 R   snapshots: fase_up, cuad_up, fase_down, cuad_down
//   4    R/W ctrl: W bit0 ARM, bit1 CONT, bit2 ABORT; R = {CONT, 1'b0}
//   5    R   status: bit0 ready, bit1 armed, [8 +: OVR_W] overrun count
//   6    R/W decim: capture on every (decim+1)th in_valid
//   7    R   cap_cnt: number of completed captures (wraps)
//   Reading address 3 while ready releases the snapshot.

module procesador_lockin_snapshot_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DECIM_W = 16,
  parameter int unsigned OVR_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_fase_up,
  input  logic [DATA_W-1:0] in_cuad_up,
  input  logic [DATA_W-1:0] in_fase_down,
  input  logic [DATA_W-1:0] in_cuad_down,
  output logic              irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_READY
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0]  snap_fase_up;
  logic [DATA_W-1:0]  snap_cuad_up;
  logic [DATA_W-1:0]  snap_fase_down;
  logic [DATA_W-1:0]  snap_cuad_down;
  logic               cont;
  logic [DECIM_W-1:0] decim;
  logic [DECIM_W-1:0] decim_cnt;
  logic [OVR_W-1:0]   ovr_cnt;
  logic [DATA_W-1:0]  cap_cnt;

  // Bus decode
  logic wr_ctrl;
  logic wr_decim;
  logic arm_req;
  logic abort_req;
  logic rd_release;

  // FSM-to-datapath controls
  logic load_decim;
  logic dec_decim;
  logic do_capture;
  logic inc_ovr;
  logic clr_ovr;

  logic [DATA_W-1:0] rd_mux;

  // Upper writedata bits have no destination in any register.
  logic unused_wdata;
  assign unused_wdata = ^writedata[DATA_W-1:DECIM_W];

  assign wr_ctrl    = write && (address == 3'd4);
  assign wr_decim   = write && (address == 3'd6);
  assign arm_req    = wr_ctrl && writedata[0];
  assign abort_req  = wr_ctrl && writedata[2];
  assign rd_release = read && (address == 3'd3);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    load_decim = 1'b0;
    dec_decim  = 1'b0;
    do_capture = 1'b0;
    inc_ovr    = 1'b0;
    clr_ovr    = 1'b0;

    // An overrun is counted whenever a strobe lands while the snapshot is
    // still held, regardless of what the bus does in the same cycle.
    if (state == ST_READY && in_valid) begin
      inc_ovr = 1'b1;
    end

    if (abort_req) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // A strobe coincident with the arm write sees IDLE and is ignored.
          if (arm_req) begin
            state_nx   = ST_ARMED;
            load_decim = 1'b1;
            clr_ovr    = 1'b1;
          end
        end
        ST_ARMED: begin
          if (in_valid) begin
            if (decim_cnt != '0) begin
              dec_decim = 1'b1;
            end else begin
              do_capture = 1'b1;
              state_nx   = ST_READY;
            end
          end
        end
        ST_READY: begin
          if (rd_release) begin
            if (cont) begin
              state_nx   = ST_ARMED;
              load_decim = 1'b1;
            end else begin
              state_nx = ST_IDLE;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cont  <= 1'b0;
      decim <= '0;
    end else begin
      if (wr_ctrl) begin
        cont <= writedata[1];
      end
      if (wr_decim) begin
        decim <= writedata[DECIM_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decimation counter, overrun counter, capture counter and snapshots
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      decim_cnt <= '0;
    end else if (load_decim) begin
      decim_cnt <= decim;
    end else if (dec_decim) begin
      decim_cnt <= decim_cnt - DECIM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_cnt <= '0;
    end else if (clr_ovr) begin
      ovr_cnt <= '0;
    end else if (inc_ovr && (ovr_cnt != '1)) begin
      ovr_cnt <= ovr_cnt + OVR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_cnt        <= '0;
      snap_fase_up   <= '0;
      snap_cuad_up   <= '0;
      snap_fase_down <= '0;
      snap_cuad_down <= '0;
    end else if (do_capture) begin
      cap_cnt        <= cap_cnt + DATA_W'(1);
      snap_fase_up   <= in_fase_up;
      snap_cuad_up   <= in_cuad_up;
      snap_fase_down <= in_fase_down;
      snap_cuad_down <= in_cuad_down;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    unique case (address)
      3'd0: rd_mux = snap_fase_up;
      3'd1: rd_mux = snap_cuad_up;
      3'd2: rd_mux = snap_fase_down;
      3'd3: rd_mux = snap_cuad_down;
      3'd4: rd_mux[1] = cont;
      3'd5: begin
        rd_mux[0]         = (state == ST_READY);
        rd_mux[1]         = (state == ST_ARMED);
        rd_mux[8 +: OVR_W] = ovr_cnt;
      end
      3'd6: rd_mux[DECIM_W-1:0] = decim;
      3'd7: rd_mux = cap_cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= (state == ST_READY);
    end
  end

endmodule

// File: tb/tb_procesador_lockin_snapshot_ctrl.sv
// Directed bench for procesador_lockin_snapshot_ctrl: hand-computed expected
// values, every comparison routed through check_eq.

module tb_procesador_lockin_snapshot_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        in_valid;
  logic [31:0] in_fase_up;
  logic [31:0] in_cuad_up;
  logic [31:0] in_fase_down;
  logic [31:0] in_cuad_down;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  always #5 clk = ~clk;

  procesador_lockin_snapshot_ctrl #(
    .DATA_W  (32),
    .DECIM_W (16),
    .OVR_W   (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .in_valid     (in_valid),
    .in_fase_up   (in_fase_up),
    .in_cuad_up   (in_cuad_up),
    .in_fase_down (in_fase_down),
    .in_cuad_down (in_cuad_down),
    .irq          (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling
  // and new inputs are set up well ahead of the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic set_inputs(input logic [31:0] base);
    in_fase_up   = base;
    in_cuad_up   = base + 32'd100;
    in_fase_down = base + 32'd200;
    in_cuad_down = base + 32'd300;
  endtask

  task automatic pulse(input logic [31:0] base);
    set_inputs(base);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;

    reset_n   = 1'b0;
    address   = 3'd0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = '0;
    in_valid  = 1'b0;
    set_inputs(32'd0);

    // Reset state
    idle(2);
    check_eq("rst_readdata", readdata, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    idle(1);

    // 1: reset while ARMED with decim=3 and CONT set
    bus_write(3'd6, 32'd3);
    bus_write(3'd4, 32'h3);
    pulse(32'd50);
    bus_read(3'd4, rd);
    check_eq("t1_ctrl_before", rd, 32'h2);
    #2 reset_n = 1'b0;
    #2;
    check_eq("t1_rst_readdata", readdata, 32'h0);
    check_eq("t1_rst_irq", {31'b0, irq}, 32'h0);
    idle(1);
    reset_n = 1'b1;
    idle(1);
    bus_read(3'd5, rd); check_eq("t1_status", rd, 32'h0);
    bus_read(3'd4, rd); check_eq("t1_ctrl", rd, 32'h0);
    bus_read(3'd6, rd); check_eq("t1_decim", rd, 32'h0);
    bus_read(3'd7, rd); check_eq("t1_capcnt", rd, 32'h0);
    bus_read(3'd0, rd); check_eq("t1_snap0", rd, 32'h0);

    // 2: decim=2, six strobes -> third one captured, three overruns
    bus_write(3'd6, 32'd2);
    bus_write(3'd4, 32'h1);
    bus_read(3'd5, rd); check_eq("t2_status_armed", rd, 32'h2);
    for (int unsigned i = 1; i <= 6; i++) begin
      pulse(32'(i));
      idle(1);
    end
    check_eq("t2_irq", {31'b0, irq}, 32'h1);
    bus_read(3'd0, rd); check_eq("t2_fase_up", rd, 32'd3);
    bus_read(3'd1, rd); check_eq("t2_cuad_up", rd, 32'd103);
    bus_read(3'd2, rd); check_eq("t2_fase_down", rd, 32'd203);
    bus_read(3'd5, rd); check_eq("t2_status", rd, 32'h0000_0301);
    bus_read(3'd7, rd); check_eq("t2_capcnt", rd, 32'd1);
    bus_read(3'd3, rd); check_eq("t2_cuad_down", rd, 32'd303);
    idle(1);
    check_eq("t2_irq_low", {31'b0, irq}, 32'h0);
    bus_read(3'd5, rd); check_eq("t2_status_idle", rd, 32'h0000_0300);

    // 4: overrun saturation, snapshot frozen, cleared on re-arm
    bus_write(3'd6, 32'd0);
    bus_write(3'd4, 32'h1);
    pulse(32'h0000_0A00);
    for (int unsigned i = 0; i < 300; i++) pulse(32'h0000_5000 + 32'(i));
    bus_read(3'd5, rd); check_eq("t4_status_sat", rd, 32'h0000_FF01);
    bus_read(3'd0, rd); check_eq("t4_snap0", rd, 32'h0000_0A00);
    bus_read(3'd2, rd); check_eq("t4_snap2", rd, 32'h0000_0A00 + 32'd200);
    bus_write(3'd4, 32'h4);
    bus_read(3'd5, rd); check_eq("t4_status_abort", rd, 32'h0000_FF00);
    bus_write(3'd4, 32'h1);
    bus_read(3'd5, rd); check_eq("t4_status_rearm", rd, 32'h0000_0002);
    pulse(32'h0000_0B00);
    bus_read(3'd7, rd); check_eq("t4_capcnt", rd, 32'd3);
    bus_read(3'd3, rd); check_eq("t4_cuad_down", rd, 32'h0000_0B00 + 32'd300);

    // 3: continuous mode, ten captures released by reads of address 3
    bus_write(3'd4, 32'h2);
    bus_read(3'd4, rd); check_eq("t3_ctrl_cont", rd, 32'h2);
    bus_write(3'd4, 32'h3);
    for (int unsigned k = 0; k < 10; k++) begin
      pulse(32'h0000_1000 + 32'(k));
      idle(1);
      check_eq($sformatf("t3_irq_hi%0d", k), {31'b0, irq}, 32'h1);
      bus_read(3'd3, rd);
      check_eq($sformatf("t3_cd%0d", k), rd, 32'h0000_1000 + 32'(k) + 32'd300);
      idle(1);
      check_eq($sformatf("t3_irq_lo%0d", k), {31'b0, irq}, 32'h0);
    end
    bus_read(3'd7, rd); check_eq("t3_capcnt", rd, 32'd13);
    bus_read(3'd5, rd); check_eq("t3_status", rd, 32'h0000_0002);
    bus_write(3'd4, 32'h4);
    bus_write(3'd4, 32'h0);
    bus_read(3'd5, rd); check_eq("t3_status_idle", rd, 32'h0);

    // 5: ARM and in_valid in the same cycle -> strobe not counted
    set_inputs(32'h0000_0C00);
    address   = 3'd4;
    writedata = 32'h1;
    write     = 1'b1;
    in_valid  = 1'b1;
    tick();
    write     = 1'b0;
    in_valid  = 1'b0;
    bus_read(3'd5, rd); check_eq("t5_status_armed", rd, 32'h2);
    bus_read(3'd7, rd); check_eq("t5_capcnt_same", rd, 32'd13);
    pulse(32'h0000_0D00);
    bus_read(3'd5, rd); check_eq("t5_status_ready", rd, 32'h1);
    bus_read(3'd0, rd); check_eq("t5_snap0", rd, 32'h0000_0D00);
    bus_read(3'd7, rd); check_eq("t5_capcnt", rd, 32'd14);
    bus_write(3'd4, 32'h5);
    bus_read(3'd5, rd); check_eq("t5_status_abort", rd, 32'h0);
    idle(1);
    check_eq("t5_irq", {31'b0, irq}, 32'h0);

    // 6: release read and in_valid together while READY, CONT=0
    bus_write(3'd4, 32'h1);
    pulse(32'h0000_0E00);
    set_inputs(32'h0000_0F00);
    address  = 3'd3;
    read     = 1'b1;
    in_valid = 1'b1;
    tick();
    read     = 1'b0;
    in_valid = 1'b0;
    check_eq("t6_readdata", readdata, 32'h0000_0E00 + 32'd300);
    bus_read(3'd5, rd); check_eq("t6_status", rd, 32'h0000_0100);
    bus_read(3'd0, rd); check_eq("t6_snap0", rd, 32'h0000_0E00);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
